// File: rtl/padring_pattern_core.sv
// Core-side padring pattern engine: synchronised pad inputs, loopback/walk/counter/LFSR drive.
// Optional pattern self-checker for an external pad loop, enabled by PADRING_PATTERN_CHECK_EN.
module padring_pattern_core #(
   parameter int               WIDTH       = 12,
   parameter int               SYNC_STAGES = 2,
   parameter int               DIV_W       = 8,
   parameter logic [WIDTH-1:0] LFSR_TAPS   = WIDTH'(12'h829)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   input  logic [WIDTH-1:0] ui_p2c,
   output logic [WIDTH-1:0] uo_c2p,
   output logic             tick,
   output logic             err_flag,
   output logic [7:0]       err_cnt
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] ui_s;
   logic [1:0]       mode_q;
   logic [DIV_W-1:0] psc;
   logic [WIDTH-1:0] walk, cnt, lfsr, lfsr_next;
   logic             mode_chg, adv;

   assign ui_s      = sync_q[SYNC_STAGES-1];
   assign mode_chg  = (mode != mode_q);
   // >= so a freshly lowered div below the running count wraps immediately
   assign adv       = !mode_chg && (psc >= div);
   assign lfsr_next = (lfsr == '0) ? WIDTH'(1)
                                   : {lfsr[WIDTH-2:0], ^(lfsr & LFSR_TAPS)};

   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], ui_p2c};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= mode;
         psc    <= '0;
         walk   <= WIDTH'(1);
         cnt    <= '0;
         lfsr   <= WIDTH'(1);
         tick   <= 1'b0;
         uo_c2p <= '0;
      end else begin
         case (mode_q)
            2'd0:    uo_c2p <= ui_s;
            2'd1:    uo_c2p <= walk;
            2'd2:    uo_c2p <= cnt;
            default: uo_c2p <= lfsr;
         endcase
         tick <= adv;
         if (mode_chg) begin
            mode_q <= mode;
            psc    <= '0;
            walk   <= WIDTH'(1);
            cnt    <= '0;
            lfsr   <= WIDTH'(1);
         end else if (adv) begin
            psc  <= '0;
            walk <= {walk[WIDTH-2:0], walk[WIDTH-1]};
            cnt  <= cnt + 1'b1;
            lfsr <= lfsr_next;
         end else begin
            psc <= psc + 1'b1;
         end
      end
   end

`ifdef PADRING_PATTERN_CHECK_EN
   localparam int BW = $clog2(SYNC_STAGES + 2);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] dly;
   logic [WIDTH-1:0] exp_v;
   logic [BW-1:0]    blank;

   // the delay line matches the loop latency through the input synchroniser
   assign exp_v = dly[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dly      <= '0;
         blank    <= BW'(SYNC_STAGES + 1);
         err_flag <= 1'b0;
         err_cnt  <= '0;
      end else begin
         dly <= {dly[SYNC_STAGES-2:0], uo_c2p};
         if (mode_chg) begin
            blank <= BW'(SYNC_STAGES + 1);
         end else if (blank != '0) begin
            blank <= blank - 1'b1;
         end else if (mode_q != 2'd0 && ui_s != exp_v) begin
            err_flag <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
      end
   end
`else
   assign err_flag = 1'b0;
   assign err_cnt  = 8'd0;
`endif

endmodule
